dot_product_ctrl: RTL and testbench

Sequencer that computes the dot product of two vectors held in two single-clock-read memories (A and B).
- Each memory has registered reads with 1-cycle latency.
- On a start pulse, issues one read per cycle to both memories in lockstep from programmable base addresses.
- Multiply-accumulates the returned pairs and presents a held result with a one-cycle done pulse.
- Sits between the vector memories and the system/testbench control logic.

---
 rtl/dotp_pkg.sv | 20 ++
 rtl/dotp_mac.sv | 41 ++++
 rtl/dot_product_ctrl.sv | 102 ++++++++++
 tb/tb_dot_product_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// Shared types and default widths for the dot-product sequencer.
// Optional build macro used by this slice: DOTP_SIGNED_EN (signed operands).
package dotp_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ACC_WIDTH  = 20;
  localparam int DEF_PROD_WIDTH = 2 * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/dotp_mac.sv
// Registered multiply-accumulate with synchronous clear and a valid qualifier.
// DOTP_SIGNED_EN selects two's-complement operands with sign-extended products.
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [ACC_WIDTH-1:0]  sum
);

  localparam int PW = prod_width(DATA_WIDTH);

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;

`ifdef DOTP_SIGNED_EN
  // Operands widened to the product width first so the low PW bits are the exact signed product.
  assign prod     = PW'($signed(a)) * PW'($signed(b));
  assign prod_ext = ACC_WIDTH'($signed(prod));
`else
  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = ACC_WIDTH'(prod);
`endif

  // sum is the value acc takes at the next edge; the controller snapshots it on completion.
  assign sum = valid ? acc + prod_ext : acc;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) acc <= '0;
    else                 acc <= sum;
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams lockstep reads from memories A and B and accumulates the pairs.
// Build option DOTP_SIGNED_EN (in dotp_mac) switches to signed element arithmetic.
module dot_product_ctrl
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  rd_en_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_en_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   idx, len_q;
  logic [ADDR_WIDTH-1:0] ba_q, bb_q;
  logic [0:0]            vld_pipe;
  logic                  rd_en, accept;
  logic [ACC_WIDTH-1:0]  acc, sum;

  assign accept = (state == IDLE) && start;

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (length == '0) ? DRAIN : READ;
      READ: begin
        rd_en = 1'b1;
        if (idx == len_q - (ADDR_WIDTH+1)'(1)) state_nx = DRAIN;
      end
      // Memory latency is one cycle, so the last pair is in flight for exactly one DRAIN cycle.
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      len_q    <= '0;
      ba_q     <= '0;
      bb_q     <= '0;
      vld_pipe <= '0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_nx;
      vld_pipe <= rd_en;
      done     <= (state == DRAIN);
      if (accept) begin
        ba_q   <= base_a;
        bb_q   <= base_b;
        len_q  <= length;
        idx    <= '0;
        result <= '0;
      end else if (state == READ) begin
        idx <= idx + (ADDR_WIDTH+1)'(1);
      end
      if (state == DRAIN) result <= sum;
    end
  end

  assign rd_en_a   = rd_en;
  assign rd_en_b   = rd_en;
  assign rd_addr_a = ba_q + idx[ADDR_WIDTH-1:0];
  assign rd_addr_b = bb_q + idx[ADDR_WIDTH-1:0];
  assign busy      = (state != IDLE);

  dotp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .valid(vld_pipe[0]),
    .a    (rd_data_a),
    .b    (rd_data_b),
    .acc  (acc),
    .sum  (sum)
  );

  // Registered accumulator is observable only through the completion snapshot.
  logic unused_acc;
  assign unused_acc = ^acc;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: directed scenarios plus randomized jobs vs. an array model.
module tb_dot_product_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 20;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0;
  logic [AW:0]   length = '0;
  logic          rd_en_a, rd_en_b, busy, done;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
  logic [CW-1:0] result;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_a(base_a), .base_b(base_b), .length(length),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .busy(busy), .done(done), .result(result)
  );

  function automatic longint elem(input logic [DW-1:0] x);
`ifdef DOTP_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  // Plain arithmetic over the memory arrays, truncated to the result width.
  function automatic logic [CW-1:0] model(input int ba, input int bb, input int n);
    longint s = 0;
    for (int i = 0; i < n; i++)
      s += elem(mem_a[(ba + i) % DEPTH]) * elem(mem_b[(bb + i) % DEPTH]);
    return CW'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'(8'h21 + i);
      mem_b[i] = DW'(8'h21 + i);
    end
  endtask

  // Must be entered just after a falling edge; returns on the falling edge where done is seen.
  task automatic run_job(input int ba, input int bb, input int n, input int poke_at,
                         output logic [CW-1:0] res);
    int cyc = 0;
    int k = 0;
    bit got_done = 0;
    base_a = AW'(ba);
    base_b = AW'(bb);
    length = (AW+1)'(n);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!got_done && cyc <= 40) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) chk("result_cleared", 32'(result), 0);
      if (done) begin
        got_done = 1;
        chk("done_latency", cyc, n + 1);
        chk("busy_at_done", 32'(busy), 0);
      end else begin
        chk("busy_in_job", 32'(busy), 1);
        chk("rd_en_lockstep", 32'(rd_en_b), 32'(rd_en_a));
        if (rd_en_a) begin
          chk("rd_addr_a", 32'(rd_addr_a), (ba + k) % DEPTH);
          chk("rd_addr_b", 32'(rd_addr_b), (bb + k) % DEPTH);
          k++;
        end
        if (cyc == poke_at) start = 1'b1;
        cyc++;
      end
    end
    chk("done_seen", 32'(got_done), 1);
    chk("read_count", k, n);
    chk("result_model", 32'(result), 32'(model(ba, bb, n)));
    res = result;
  endtask

  initial begin
    logic [CW-1:0] r;
    logic [CW-1:0] exp6;
    init_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en_a | rd_en_b), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(0, 0, 1, -1, r);
    chk("len1_const", 32'(r), 1089);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("result_held", 32'(result), 1089);

    run_job(0, 0, 16, -1, r);
    chk("len16_const", 32'(r), 26584);
    // Back-to-back: next job is accepted on the edge that ends the done cycle.
    run_job(15, 15, 2, -1, r);
    chk("wrap_const", 32'(r), 3393);
    run_job(3, 9, 0, -1, r);
    chk("len0_const", 32'(r), 0);
    run_job(0, 0, 16, 2, r);
    chk("ignored_start", 32'(r), 26584);
    @(negedge clk);
    chk("no_restart_busy", 32'(busy), 0);

    // Reset in the middle of a job.
    base_a = '0; base_b = '0; length = 5'd16; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rd_en", 32'(rd_en_a | rd_en_b), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done | busy), 0);
    end
    run_job(0, 0, 2, -1, r);
    chk("after_rst_const", 32'(r), 2245);

    mem_a[0] = 8'hFF;
    mem_b[0] = 8'h02;
`ifdef DOTP_SIGNED_EN
    exp6 = 20'hFFFFE;
`else
    exp6 = 20'd510;
`endif
    @(negedge clk);
    run_job(0, 0, 1, -1, r);
    chk("ext_const", 32'(r), 32'(exp6));

    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
    for (int j = 0; j < 12; j++) begin
      int ba = int'($urandom_range(0, DEPTH - 1));
      int bb = int'($urandom_range(0, DEPTH - 1));
      int n  = int'($urandom_range(0, DEPTH));
      int pk = (j % 3 == 0 && n > 3) ? 1 : -1;
      if (j % 2 == 1) @(negedge clk);
      run_job(ba, bb, n, pk, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
